nanop_mem_responder: RTL and testbench
======================================

Name: nanop_mem_responder

Overview:
- Memory-side responder for the nanoprocessor bus. It serves the processor's instruction/data fetches and STA writes from a 256x8 synchronous RAM.
- It also decodes one memory-mapped output register.
- It provides a byte-stream program loader that holds the processor in reset while a program is written into RAM, then releases it.
- It sits between the nanoprocessor core (PC/ALU/CTRL datapath) and the board-level loader/IO.

Parameters:
- OUT_ADDR, 8'hFF, address whose writes also update out_port.
- LOAD_BASE, 8'h00, first RAM address written by the loader.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a load session.
- run  in  1  one-cycle pulse: release processor without loading.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_ready  out  1  responder accepts ld_data this cycle.
- cpu_reset_n  out  1  drives processor reset_n; low except in RUN.
- cpu_addr  in  8  processor address bus.
- cpu_write  in  1  processor write strobe (WRITE).
- cpu_wdata  in  8  processor write data (accumulator).
- cpu_rdata  out  8  registered RAM read data to processor.
- out_port  out  8  output register.
- out_strobe  out  1  one-cycle pulse when out_port is written.
- busy  out  1  high in LEN or LOAD.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset values: state=IDLE, ld_ready=0, cpu_reset_n=0, cpu_rdata=8'h00, out_port=8'h00, out_strobe=0, busy=0, internal count=0, ptr=LOAD_BASE. RAM contents are not cleared.
- Output decoding: ld_ready, busy and cpu_reset_n decode from the state register only. No combinational path exists from inputs.
  - ld_ready = (state==LEN || state==LOAD).
  - cpu_reset_n = (state==RUN).
- States: IDLE, LEN, LOAD, RUN.
- IDLE:
  - start -> LEN.
  - else run -> RUN.
  - start has priority when both are high.
- LEN: on ld_valid&&ld_ready:
  - count <= (ld_data==0) ? 256 : ld_data. count is 9 bits.
  - ptr <= LOAD_BASE.
  - -> LOAD.
- LOAD: on each ld_valid&&ld_ready:
  - RAM[ptr] <= ld_data.
  - ptr <= ptr+1, wrapping modulo 256.
  - count <= count-1.
  - The handshake that makes count go 1->0 also moves state -> RUN. The processor leaves reset the following cycle.
  - ld_valid low: hold; no write.
- RUN:
  - cpu_write=1: RAM[cpu_addr] <= cpu_wdata.
  - cpu_write=1 && cpu_addr==OUT_ADDR: additionally out_port <= cpu_wdata and out_strobe=1 for exactly the next cycle. The RAM location is written too.
  - start in RUN -> LEN. cpu_reset_n drops the next cycle and the program is reloaded.
  - run in RUN is ignored.
- Reads, in every state: cpu_rdata <= RAM[cpu_addr] each cycle, giving one-cycle latency.
  - Read-during-write to the same address returns the old data.
- Writes outside RUN: cpu_write is ignored.
- start during LEN/LOAD: ignored; the session continues.
- Reset mid-load: returns to IDLE. Partial RAM contents are retained, count is cleared, cpu_reset_n=0.
- ptr wrap: a 256-byte load with LOAD_BASE!=0 wraps past 8'hFF to 8'h00. This is legal.

Test Plan:
- Reset then run pulse -> cpu_reset_n=1 one cycle after run. Processor reads RAM with 1-cycle latency: cpu_addr=8'h05 at cycle t gives RAM[5] on cpu_rdata at t+1.
- start; stream 03,AA,BB,CC with ld_valid always high -> bytes written to RAM[0..2]. busy high for 4 handshakes. cpu_reset_n rises the cycle after CC is accepted. Readback of addr 0,1,2 gives AA,BB,CC.
- Same load with ld_valid toggling 1/0 every cycle -> identical RAM contents. No writes occur on ld_valid=0 cycles. Completion is delayed accordingly.
- In RUN, cpu_write=1, cpu_addr=8'hFF, cpu_wdata=8'h5A -> out_port=8'h5A and out_strobe high for exactly one cycle. A read of addr FF next cycle returns 5A. A write to 8'h10 leaves out_strobe low.
- Length byte 00, then 256 bytes of value i -> RAM[i]=i for all i. Transition to RUN occurs after the 256th byte.
- Reset asserted after 2 of 3 data bytes -> IDLE, ld_ready=0, cpu_reset_n=0, RAM[0..1] retain the loaded values. start in RUN -> cpu_reset_n=0 next cycle and state LEN.

Source files
------------

// File: rtl/nanop_mem_responder.sv
// Nanoprocessor memory responder: 256x8 sync RAM, one output register,
// and a byte-stream program loader that holds the core in reset.
module nanop_mem_responder #(
  parameter logic [7:0] OUT_ADDR  = 8'hFF,
  parameter logic [7:0] LOAD_BASE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       run,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       cpu_reset_n,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_write,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic [7:0] out_port,
  output logic       out_strobe,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LEN  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [8:0] count_q, count_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] rdata_q;
  logic [7:0] out_q;
  logic       strobe_q;
  logic [7:0] mem_q [256];

  logic       hs;
  logic       ram_we;
  logic [7:0] ram_wa;
  logic [7:0] ram_wd;
  logic       out_wr;

  assign ld_ready    = (state_q == LEN) || (state_q == LOAD);
  assign busy        = ld_ready;
  assign cpu_reset_n = (state_q == RUN);
  assign cpu_rdata   = rdata_q;
  assign out_port    = out_q;
  assign out_strobe  = strobe_q;

  assign hs = ld_valid && ld_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (start)    state_d = LEN;
        else if (run) state_d = RUN;
      end
      LEN: begin
        if (hs) begin
          count_d = (ld_data == 8'h00) ? 9'd256 : {1'b0, ld_data};
          ptr_d   = LOAD_BASE;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          ptr_d   = ptr_q + 8'd1;
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) state_d = RUN;
        end
      end
      RUN: begin
        if (start) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader owns the write port in LOAD; the core only in RUN.
  assign ram_we = !reset &&
                  (((state_q == LOAD) && ld_valid) ||
                   ((state_q == RUN) && cpu_write));
  assign ram_wa = (state_q == LOAD) ? ptr_q : cpu_addr;
  assign ram_wd = (state_q == LOAD) ? ld_data : cpu_wdata;
  assign out_wr = (state_q == RUN) && cpu_write &&
                  (cpu_addr == OUT_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 9'd0;
      ptr_q    <= LOAD_BASE;
      rdata_q  <= 8'h00;
      out_q    <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      rdata_q  <= mem_q[cpu_addr];
      strobe_q <= out_wr;
      if (out_wr) out_q <= cpu_wdata;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_wa] <= ram_wd;
  end

endmodule

// File: tb/tb_nanop_mem_responder.sv
// Directed bench for nanop_mem_responder with a read-data scoreboard.
module tb_nanop_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       run;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       cpu_reset_n;
  logic [7:0] cpu_addr;
  logic       cpu_write;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic [7:0] out_port;
  logic       out_strobe;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] data_q [$];

  nanop_mem_responder #(
    .OUT_ADDR (8'hFF),
    .LOAD_BASE(8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .run        (run),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .cpu_reset_n(cpu_reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a);
    cpu_addr = a;
    exp_q.push_back(model[a]);
    cyc();
    chk($sformatf("rd_%02h", a), {24'd0, cpu_rdata}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
    model[a]  = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] len, input int n,
                      input bit toggle, input bit start_mid);
    logic [7:0] p;
    p = 8'h00;
    chk("busy_len", {31'd0, busy}, 32'd1);
    ld_valid = 1'b1;
    ld_data  = len;
    cyc();
    for (int k = 0; k < n; k++) begin
      if (toggle) begin
        ld_valid = 1'b0;
        ld_data  = 8'hEE;
        cyc();
      end
      chk("busy_load", {31'd0, busy}, 32'd1);
      chk("rstn_load", {31'd0, cpu_reset_n}, 32'd0);
      ld_valid = 1'b1;
      ld_data  = data_q[k];
      start    = start_mid && (k == 0);
      cyc();
      model[p] = data_q[k];
      p        = p + 8'd1;
      start    = 1'b0;
    end
    ld_valid = 1'b0;
    chk("rstn_done", {31'd0, cpu_reset_n}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; run = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00;
    cpu_addr = 8'h00; cpu_write = 1'b0; cpu_wdata = 8'h00;
    cyc();
    cyc();
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_rstn", {31'd0, cpu_reset_n}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_out", {24'd0, out_port}, 32'd0);
    chk("rst_strobe", {31'd0, out_strobe}, 32'd0);
    reset = 1'b0;
    cyc();

    // run pulse releases the core
    run = 1'b1;
    cyc();
    run = 1'b0;
    chk("run_rstn", {31'd0, cpu_reset_n}, 32'd1);
    cpu_wr(8'h05, 8'h77);
    rd(8'h05);
    // read-during-write returns old data
    cpu_wr(8'h05, 8'h88);
    chk("rdw_old", {24'd0, cpu_rdata}, 32'h77);
    rd(8'h05);

    // start in RUN drops reset and enters LEN
    pulse_start();
    chk("restart_rstn", {31'd0, cpu_reset_n}, 32'd0);
    chk("restart_ready", {31'd0, ld_ready}, 32'd1);
    data_q = '{8'hAA, 8'hBB, 8'hCC};
    load(8'h03, 3, 1'b0, 1'b0);
    rd(8'h00); rd(8'h01); rd(8'h02);

    // toggling valid, start ignored mid-load
    cpu_wr(8'h00, 8'h00);
    cpu_wr(8'h01, 8'h00);
    cpu_wr(8'h02, 8'h00);
    pulse_start();
    data_q = '{8'h1A, 8'h2B, 8'h3C};
    load(8'h03, 3, 1'b1, 1'b1);
    rd(8'h00); rd(8'h01); rd(8'h02); rd(8'h03);

    // output register
    cpu_wr(8'hFF, 8'h5A);
    chk("out_port", {24'd0, out_port}, 32'h5A);
    chk("strobe_hi", {31'd0, out_strobe}, 32'd1);
    rd(8'hFF);
    chk("strobe_lo", {31'd0, out_strobe}, 32'd0);
    cpu_wr(8'h10, 8'h33);
    chk("strobe_10", {31'd0, out_strobe}, 32'd0);
    chk("out_keep", {24'd0, out_port}, 32'h5A);
    rd(8'h10);

    // full 256-byte load
    pulse_start();
    data_q.delete();
    for (int i = 0; i < 256; i++) data_q.push_back(8'(i));
    load(8'h00, 256, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) rd(8'(i));

    // reset mid-load keeps partial contents
    pulse_start();
    ld_valid = 1'b1; ld_data = 8'h03; cyc();
    ld_data = 8'h11; cyc();
    ld_data = 8'h22; cyc();
    model[0] = 8'h11;
    model[1] = 8'h22;
    ld_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_ready", {31'd0, ld_ready}, 32'd0);
    chk("mid_rstn", {31'd0, cpu_reset_n}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    rd(8'h00); rd(8'h01); rd(8'h02);

    // start beats run in IDLE
    start = 1'b1; run = 1'b1;
    cyc();
    start = 1'b0; run = 1'b0;
    chk("prio_busy", {31'd0, busy}, 32'd1);
    chk("prio_rstn", {31'd0, cpu_reset_n}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
